// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding and default width for the multiply/divide unit.
// No logic; constants and types only.
// Imported by muldiv_sequencer and muldiv_iter_step.
package muldiv_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MFHI  = 3'b101;
    localparam logic [2:0] OP_MFLO  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Ops that start a multi-cycle multiply or divide.
    function automatic logic is_arith_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Ops that read HI or LO.
    function automatic logic is_read_op(input logic [2:0] op);
        return (op == OP_MFHI) || (op == OP_MFLO);
    endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One iteration of shift-add multiply or restoring divide (one quotient bit, MSB first).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the sequencer decides when the result is registered.
module muldiv_iter_step
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                      is_div,
    input  logic [2*DATA_WIDTH-1:0]   acc,
    input  logic [2*DATA_WIDTH-1:0]   mcand,
    input  logic [DATA_WIDTH-1:0]     mplier,
    output logic [2*DATA_WIDTH-1:0]   acc_nxt,
    output logic [2*DATA_WIDTH-1:0]   mcand_nxt,
    output logic [DATA_WIDTH-1:0]     mplier_nxt
);

    // Divide reuses the registers: acc low half = partial remainder,
    // mcand low half = divisor, mplier = dividend shifting out / quotient shifting in.
    logic [DATA_WIDTH:0] rem_sh;
    logic [DATA_WIDTH:0] divisor_ext;

    // Compute the next accumulator / operand registers for the selected op class.
    always_comb begin
        acc_nxt     = acc;
        mcand_nxt   = mcand;
        mplier_nxt  = mplier;
        rem_sh      = {acc[DATA_WIDTH-1:0], mplier[DATA_WIDTH-1]};
        divisor_ext = {1'b0, mcand[DATA_WIDTH-1:0]};
        if (is_div) begin
            if (rem_sh >= divisor_ext) begin
                acc_nxt    = {{DATA_WIDTH{1'b0}}, rem_sh[DATA_WIDTH-1:0] - divisor_ext[DATA_WIDTH-1:0]};
                mplier_nxt = {mplier[DATA_WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt    = {{DATA_WIDTH{1'b0}}, rem_sh[DATA_WIDTH-1:0]};
                mplier_nxt = {mplier[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            if (mplier[0]) begin
                acc_nxt = acc + mcand;
            end
            mcand_nxt  = mcand << 1;
            mplier_nxt = mplier >> 1;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU with HI/LO pair and MFHI/MFLO reads; optional MULDIV_EARLY_EXIT_EN.
// Latency: DATA_WIDTH RUN cycles + 1 FIX cycle; new HI/LO visible DATA_WIDTH+2 cycles after accept.
// Backpressure: oStall holds arith and read requests while not IDLE; NOP/reserved never stall.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iValid,
    input  logic [2:0]            iOp,
    input  logic [DATA_WIDTH-1:0] iRs,
    input  logic [DATA_WIDTH-1:0] iRt,
    output logic                  oStall,
    output logic                  oBusy,
    output logic [DATA_WIDTH-1:0] oResult,
    output logic                  oResultValid,
    output logic [DATA_WIDTH-1:0] oHI,
    output logic [DATA_WIDTH-1:0] oLO
);

    localparam int W = DATA_WIDTH;

    state_t             state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic               is_div_r;
    logic               neg_res_r;   // product / quotient sign flip
    logic               rs_neg_r;    // remainder follows dividend sign
    logic [2*W-1:0]     acc, mcand;
    logic [W-1:0]       mplier, rs_raw, hi, lo;

    logic [2*W-1:0]     acc_nxt, mcand_nxt;
    logic [W-1:0]       mplier_nxt;

    logic               arith_req, read_req, accept, last_iter;
    logic               signed_op, rs_neg, rt_neg, op_div;
    logic [W-1:0]       rs_abs, rt_abs;
    logic [2*W-1:0]     prod_fix;
    logic [W-1:0]       hi_fix, lo_fix;

    muldiv_iter_step #(.DATA_WIDTH(W)) u_step (
        .is_div     (is_div_r),
        .acc        (acc),
        .mcand      (mcand),
        .mplier     (mplier),
        .acc_nxt    (acc_nxt),
        .mcand_nxt  (mcand_nxt),
        .mplier_nxt (mplier_nxt)
    );

    // Request decode, handshake and operand magnitude/sign extraction.
    always_comb begin
        arith_req = iValid && is_arith_op(iOp);
        read_req  = iValid && is_read_op(iOp);
        oStall    = (arith_req || read_req) && (state != ST_IDLE);
        accept    = arith_req && !oStall;
        signed_op = (iOp == OP_MULT) || (iOp == OP_DIV);
        op_div    = (iOp == OP_DIV) || (iOp == OP_DIVU);
        rs_neg    = signed_op && iRs[W-1];
        rt_neg    = signed_op && iRt[W-1];
        rs_abs    = rs_neg ? -iRs : iRs;
        rt_abs    = rt_neg ? -iRt : iRt;
    end

    // Read port and status outputs; reads are served only while IDLE.
    always_comb begin
        oBusy        = (state != ST_IDLE);
        oResultValid = read_req && (state == ST_IDLE);
        oResult      = '0;
        if (oResultValid) begin
            oResult = (iOp == OP_MFHI) ? hi : lo;
        end
        oHI = hi;
        oLO = lo;
    end

    // Sign correction and divide-by-zero override applied in FIX.
    always_comb begin
        prod_fix = neg_res_r ? -acc : acc;
        hi_fix   = prod_fix[2*W-1:W];
        lo_fix   = prod_fix[W-1:0];
        if (is_div_r) begin
            if (mcand[W-1:0] == '0) begin
                lo_fix = '1;
                hi_fix = rs_raw;
            end else begin
                lo_fix = neg_res_r ? -mplier : mplier;
                hi_fix = rs_neg_r ? -acc[W-1:0] : acc[W-1:0];
            end
        end
    end

    // Next-state logic; a multiply may leave RUN early once the multiplier is exhausted.
    always_comb begin
        state_nxt = state;
        last_iter = (cnt == CNT_WIDTH'(W-1));
`ifdef MULDIV_EARLY_EXIT_EN
        if (!is_div_r && (mplier_nxt == '0)) begin
            last_iter = 1'b1;
        end
`endif
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_RUN;
            ST_RUN:  if (last_iter) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: load operands on accept, iterate in RUN, commit HI/LO in FIX.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            cnt       <= '0;
            is_div_r  <= 1'b0;
            neg_res_r <= 1'b0;
            rs_neg_r  <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            rs_raw    <= '0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cnt       <= '0;
                        is_div_r  <= op_div;
                        neg_res_r <= rs_neg ^ rt_neg;
                        rs_neg_r  <= rs_neg;
                        acc       <= '0;
                        rs_raw    <= iRs;
                        mcand     <= {{W{1'b0}}, (op_div ? rt_abs : rs_abs)};
                        mplier    <= op_div ? rs_abs : rt_abs;
                    end
                end
                ST_RUN: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand_nxt;
                    mplier <= mplier_nxt;
                    cnt    <= cnt + CNT_WIDTH'(1);
                end
                ST_FIX: begin
                    hi  <= hi_fix;
                    lo  <= lo_fix;
                    cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed vectors, expected HI/LO/read data queued at issue.
// A negedge monitor pops and compares on busy falling (arith) and on accepted reads.
// Completion cycle is checked against a latency model that knows the early-exit build.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         iClk = 1'b0;
    logic         iRst_n = 1'b0;
    logic         iValid = 1'b0;
    logic [2:0]   iOp = OP_NOP;
    logic [W-1:0] iRs = '0;
    logic [W-1:0] iRt = '0;
    logic         oStall, oBusy, oResultValid;
    logic [W-1:0] oResult, oHI, oLO;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           done_cyc;
    } arith_exp_t;

    arith_exp_t   aq[$];
    logic [W-1:0] rq[$];
    arith_exp_t   mon_e;
    logic [W-1:0] mon_r;
    bit           prev_busy = 1'b0;
    bit           rst_edge = 1'b0;

    muldiv_sequencer #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
        .iClk         (iClk),
        .iRst_n       (iRst_n),
        .iValid       (iValid),
        .iOp          (iOp),
        .iRs          (iRs),
        .iRt          (iRt),
        .oStall       (oStall),
        .oBusy        (oBusy),
        .oResult      (oResult),
        .oResultValid (oResultValid),
        .oHI          (oHI),
        .oLO          (oLO)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) begin
        cyc      <= cyc + 1;
        rst_edge <= !iRst_n;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycles from acceptance to the first cycle with new HI/LO and IDLE.
    function automatic int lat(input logic [2:0] op, input logic [W-1:0] rt);
        int bl;
        logic [W-1:0] m;
        bl = 0;
        m  = ((op == OP_MULT) && rt[W-1]) ? -rt : rt;
        for (int i = 0; i < W; i++) if (m[i]) bl = i + 1;
        if (bl < 1) bl = 1;
`ifdef MULDIV_EARLY_EXIT_EN
        if ((op == OP_MULT) || (op == OP_MULTU)) return bl + 2;
`endif
        return W + 2;
    endfunction

    // Monitor: compare reads when accepted and arith results when busy drops.
    always @(negedge iClk) begin
        if (iRst_n && iValid && (iOp == OP_MFHI || iOp == OP_MFLO) && !oStall) begin
            if (rq.size() == 0) begin
                checks++; errors++;
                $display("FAIL read_unexpected: got read at cycle %0d, expected none", cyc);
            end else begin
                mon_r = rq.pop_front();
                chk("read_valid", {63'd0, oResultValid}, 64'd1);
                chk("read_data", {32'd0, oResult}, {32'd0, mon_r});
            end
        end
        if (prev_busy && !oBusy && !rst_edge) begin
            if (aq.size() == 0) begin
                checks++; errors++;
                $display("FAIL done_unexpected: got completion at cycle %0d, expected none", cyc);
            end else begin
                mon_e = aq.pop_front();
                chk("result_hi", {32'd0, oHI}, {32'd0, mon_e.hi});
                chk("result_lo", {32'd0, oLO}, {32'd0, mon_e.lo});
                chk("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
            end
        end
        prev_busy = oBusy;
    end

    // Present an arith request until accepted; optionally queue its expected result.
    task automatic do_arith(input string name, input logic [2:0] op, input logic [W-1:0] rs,
                            input logic [W-1:0] rt, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                            input bit track, output int t);
        int n;
        arith_exp_t e;
        n = 0;
        iValid = 1'b1; iOp = op; iRs = rs; iRt = rt;
        @(negedge iClk);
        while (oStall && n < 100) begin
            @(negedge iClk);
            n++;
        end
        t = cyc;
        if (oStall) begin
            checks++; errors++;
            $display("FAIL %s accept_timeout: got stall after %0d cycles, expected accept", name, n);
        end else if (track) begin
            e.hi = ehi; e.lo = elo; e.done_cyc = cyc + lat(op, rt);
            aq.push_back(e);
        end
        @(posedge iClk); #1;
        iValid = 1'b0; iOp = OP_NOP;
    endtask

    // Present a read until accepted; check acceptance cycle when exp_cyc >= 0.
    task automatic do_read(input string name, input logic [2:0] op, input logic [W-1:0] exp,
                           input int exp_cyc);
        int n;
        n = 0;
        rq.push_back(exp);
        iValid = 1'b1; iOp = op;
        @(negedge iClk);
        while (oStall && n < 100) begin
            @(negedge iClk);
            n++;
        end
        if (oStall) begin
            checks++; errors++;
            rq.delete();
            $display("FAIL %s accept_timeout: got stall after %0d cycles, expected accept", name, n);
        end else if (exp_cyc >= 0) begin
            chk(name, 64'(cyc), 64'(exp_cyc));
        end
        @(posedge iClk); #1;
        iValid = 1'b0; iOp = OP_NOP;
    endtask

    initial begin
        int t;
        int n;

        iRst_n = 1'b0;
        repeat (3) @(posedge iClk);
        #1 iRst_n = 1'b1;
        @(negedge iClk);
        chk("rst_busy", {63'd0, oBusy}, 64'd0);
        chk("rst_hi", {32'd0, oHI}, 64'd0);
        chk("rst_lo", {32'd0, oLO}, 64'd0);
        chk("rst_result", {32'd0, oResult}, 64'd0);
        chk("rst_result_valid", {63'd0, oResultValid}, 64'd0);
        chk("rst_stall", {63'd0, oStall}, 64'd0);
        @(posedge iClk); #1;

        do_read("rd_reset_hi", OP_MFHI, 32'h0, -1);

        do_arith("mult_7_m3", OP_MULT, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1, t);
        // Busy now: NOP/reserved pass, reads stall, HI/LO hold.
        iValid = 1'b1; iOp = OP_NOP; #1;
        chk("stall_nop_busy", {63'd0, oStall}, 64'd0);
        iOp = 3'b111; #1;
        chk("stall_rsvd_busy", {63'd0, oStall}, 64'd0);
        iOp = OP_MFHI; #1;
        chk("stall_read_busy", {63'd0, oStall}, 64'd1);
        chk("rv_while_busy", {63'd0, oResultValid}, 64'd0);
        chk("hi_hold_busy", {32'd0, oHI}, 64'd0);
        iValid = 1'b0; iOp = OP_NOP;

        do_arith("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, t);
        do_arith("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, t);

        do_arith("multu_64k", OP_MULTU, 32'h10000, 32'h10000, 32'h1, 32'h0, 1'b1, t);
        do_read("mflo_accept_cycle", OP_MFLO, 32'h0, t + lat(OP_MULTU, 32'h10000));
        do_read("mfhi_after", OP_MFHI, 32'h1, -1);

        do_arith("div_by_zero", OP_DIV, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF, 1'b1, t);
        do_arith("div_min_m1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b1, t);

        // Abort a multiply with reset; LO currently holds 0x80000000.
        do_arith("mult_abort", OP_MULT, 32'd7, 32'h40000000, 32'h0, 32'h0, 1'b0, t);
        repeat (8) @(posedge iClk);
        #1;
        chk("lo_hold_abort", {32'd0, oLO}, 64'h80000000);
        chk("busy_before_abort", {63'd0, oBusy}, 64'd1);
        @(posedge iClk); #1 iRst_n = 1'b0;
        @(posedge iClk); #1 iRst_n = 1'b1;
        chk("abort_busy", {63'd0, oBusy}, 64'd0);
        chk("abort_hi", {32'd0, oHI}, 64'd0);
        chk("abort_lo", {32'd0, oLO}, 64'd0);
        iValid = 1'b1; iOp = OP_MULTU; iRs = 32'd3; iRt = 32'd4; #1;
        chk("abort_stall", {63'd0, oStall}, 64'd0);
        do_arith("multu_3_4", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b1, t);

        do_arith("multu_5_3", OP_MULTU, 32'd5, 32'd3, 32'd0, 32'd15, 1'b1, t);
        do_arith("multu_5_0", OP_MULTU, 32'd5, 32'd0, 32'd0, 32'd0, 1'b1, t);

        n = 0;
        while ((aq.size() != 0 || rq.size() != 0) && n < 200) begin
            @(posedge iClk);
            n++;
        end
        repeat (2) @(posedge iClk);
        if (aq.size() != 0 || rq.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: got %0d arith and %0d reads pending, expected 0", aq.size(), rq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide unit with its own HI/LO register pair; executes MULT, MULTU, DIV, DIVU, MFHI and MFLO.
- Sits beside the ALU in the EX stage. Takes operands from the EX stage and stalls the pipeline while busy.
- Sequences an iterative shift-add multiplier and a restoring divider, one bit per cycle.
- Serves MFHI/MFLO reads and blocks them until any pending result has been written.

Parameters:
- DATA_WIDTH, 32, operand/HI/LO width; product is 2*DATA_WIDTH.
- CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- iClk  in  1  clock; all state updates on rising edge.
- iRst_n  in  1  reset, synchronous, active-low.
- iValid  in  1  request valid from EX stage.
- iOp  in  3  request op: 000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MFHI, 110 MFLO, 111 reserved (treated as NOP).
- iRs  in  DATA_WIDTH  multiplicand / dividend.
- iRt  in  DATA_WIDTH  multiplier / divisor.
- oStall  out  1  request cannot be accepted this cycle; hold the pipeline.
- oBusy  out  1  state != IDLE.
- oResult  out  DATA_WIDTH  MFHI/MFLO read data.
- oResultValid  out  1  oResult valid this cycle.
- oHI  out  DATA_WIDTH  current HI register.
- oLO  out  DATA_WIDTH  current LO register.

Behaviour:
- Clock and reset: one clock, iClk. Reset iRst_n is synchronous and active-low.
- Reset (iRst_n=0 at an edge), including mid-operation:
  - state=IDLE, counter=0, HI=LO=0.
  - Internal accumulators cleared; any in-flight operation is discarded.
- Reset values of outputs: oBusy=0, oHI=oLO=0, oResult=0. oStall and oResultValid are combinational and follow the reset state.
- Request classes:
  - "arith request" = iValid and iOp in {001..100}.
  - "read request" = iValid and iOp in {101,110}.
  - NOP and reserved codes are ignored and never stall.
- oStall (combinational) = (arith request or read request) and state != IDLE.
- A request is accepted when iValid=1, it is an arith or read request, and oStall=0.
- Read (state IDLE):
  - oResult = HI for MFHI, LO for MFLO, same cycle, combinational.
  - oResultValid=1 the same cycle.
  - Otherwise oResult=0 and oResultValid=0.
- FSM states: IDLE, RUN, FIX.
  - IDLE -> RUN on an accepted arith request. Latches op, sign flags and operand magnitudes (abs value for signed ops), clears accumulator, counter=0.
  - RUN, one iteration per cycle:
    - Multiply: if multiplier LSB=1, add shifted multiplicand to the 2W accumulator; then shift multiplicand left and multiplier right.
    - Divide: restoring shift/subtract producing one quotient bit (MSB first).
    - The counter increments every RUN cycle. RUN -> FIX when counter reaches DATA_WIDTH-1, i.e. exactly DATA_WIDTH RUN cycles.
  - FIX, single cycle: apply sign correction and write HI/LO at the end of the cycle; FIX -> IDLE.
- Latency: request accepted at cycle T gives RUN cycles T+1..T+DATA_WIDTH and FIX at T+DATA_WIDTH+1. New HI/LO and IDLE are visible at T+DATA_WIDTH+2 (T+34 for width 32).
- HI/LO are unchanged until FIX, so oHI/oLO hold the old values throughout.
- Result mapping:
  - MULT/MULTU: HI = product[2W-1:W], LO = product[W-1:0]. MULT negates the 2W product when sign(Rs) xor sign(Rt).
  - DIV/DIVU: LO = quotient, HI = remainder.
  - DIV sign rules: quotient negated when the operand signs differ; remainder takes the dividend's sign.
- Boundary cases:
  - DIV of -2^(W-1) by -1: LO = 0x80000000, HI = 0 (natural wrap, no trap).
  - Divisor 0, signed or unsigned: full latency kept; FIX forces LO = all ones and HI = iRs as latched.
  - An arith request arriving in RUN/FIX is stalled, never queued. Same for a read request.
  - An arith or read request presented in the same cycle FIX completes still sees oStall=1; it is accepted on the next cycle.

Optional Feature:
- Macro: MULDIV_EARLY_EXIT_EN.
- Defined: a multiply leaves RUN when the post-shift remaining multiplier magnitude is 0, or the counter hits DATA_WIDTH-1.
  - RUN cycles = max(1, bit-length of |Rt|).
  - The result is identical to the full-latency result.
  - Divide always takes DATA_WIDTH cycles.
- Undefined: every arith op takes exactly DATA_WIDTH RUN cycles.

Decomposition:
- Package muldiv_pkg holds:
  - op code localparams (OP_NOP, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO);
  - FSM state encoding (ST_IDLE, ST_RUN, ST_FIX);
  - default DATA_WIDTH.
- One sub-module, muldiv_iter_step: combinational single iteration. Inputs are op class, accumulator, multiplicand/divisor and multiplier/quotient registers; outputs are next values. The sequencer owns the FSM, counter, sign handling and HI/LO.

Test Plan:
- MULT iRs=7, iRt=0xFFFFFFFD (-3) accepted at T -> oBusy=1 T+1..T+33; at T+34 oHI=0xFFFFFFFF, oLO=0xFFFFFFEB.
- DIVU iRs=100, iRt=7 -> oLO=0x0000000E, oHI=0x00000002 at T+34. DIV iRs=-7, iRt=2 -> oLO=0xFFFFFFFD, oHI=0xFFFFFFFF.
- MULTU 0x10000 * 0x10000 at T; MFLO held valid from T+1 -> oStall=1 T+1..T+33, accepted at T+34 with oResult=0x00000000, oResultValid=1. MFHI then returns 0x00000001.
- DIV iRs=0x1234, iRt=0 -> T+34: oLO=0xFFFFFFFF, oHI=0x00001234. DIV 0x80000000 / 0xFFFFFFFF -> oLO=0x80000000, oHI=0.
- MULT started with HI/LO preloaded nonzero; iRst_n=0 at T+10 -> next cycle oBusy=0, oHI=oLO=0, oStall=0. A fresh MULTU 3*4 then gives oLO=12.
- With MULDIV_EARLY_EXIT_EN: MULTU 5*3 at T -> 2 RUN cycles, oLO=15 visible at T+4; MULTU 5*0 -> oLO=0 at T+3. Without the macro both complete at T+34.
